// File: rtl/down_timer.sv
// Loadable down-counting timer with prescaler, one-shot/periodic modes,
// a one-cycle expiry pulse and a sticky interrupt flag.
module down_timer #(
  parameter int WIDTH    = 8,
  parameter int PS_WIDTH = 4
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                load,
  input  logic [WIDTH-1:0]    load_value,
  input  logic                start,
  input  logic                stop,
  input  logic                periodic,
  input  logic [PS_WIDTH-1:0] prescale,
  input  logic                irq_clear,
  output logic [WIDTH-1:0]    count,
  output logic                running,
  output logic                expired,
  output logic                irq
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state;
  logic [WIDTH-1:0]    reload;
  logic [PS_WIDTH-1:0] ps;
  logic                tick;
  logic                expiry;

  // Load and Stop both pre-empt counting for the cycle; Start is a no-op in RUN.
  assign tick    = (state == RUN) && !load && !stop && (ps >= prescale);
  assign expiry  = tick && (count == WIDTH'(1));
  assign running = (state == RUN);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      count   <= '0;
      reload  <= '0;
      ps      <= '0;
      expired <= 1'b0;
      irq     <= 1'b0;
    end else begin
      expired <= expiry;
      irq     <= expiry | (irq & ~irq_clear);

      if (load) begin
        reload <= load_value;
        count  <= load_value;
        ps     <= '0;
        if (stop || load_value == '0)
          state <= IDLE;
        else if (start || state == RUN)
          state <= RUN;
        else
          state <= IDLE;
      end else if (stop) begin
        if (state == RUN)
          state <= IDLE;
      end else if (start && state != RUN) begin
        if (count != '0) begin
          state <= RUN;
          ps    <= '0;
        end else if (reload != '0) begin
          count <= reload;
          state <= RUN;
          ps    <= '0;
        end
      end else if (state == RUN) begin
        if (tick) begin
          ps <= '0;
          if (expiry) begin
            if (periodic) begin
              count <= reload;
            end else begin
              count <= '0;
              state <= DONE;
            end
          end else if (count > WIDTH'(1)) begin
            count <= count - 1'b1;
          end
        end else begin
          ps <= ps + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_down_timer.sv
// Directed bench for down_timer: a cycle model of the timer rules checked
// every cycle, plus hand-computed literal expectations along the sequence.
module tb_down_timer;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       load = 1'b0, start = 1'b0, stop = 1'b0, periodic = 1'b0, irq_clear = 1'b0;
  logic [7:0] load_value = '0;
  logic [3:0] prescale = '0;
  logic [7:0] count;
  logic       running, expired, irq;

  int checks = 0;
  int errors = 0;

  down_timer #(.WIDTH(8), .PS_WIDTH(4)) dut (
    .clock(clock), .reset_n(reset_n), .load(load), .load_value(load_value),
    .start(start), .stop(stop), .periodic(periodic), .prescale(prescale),
    .irq_clear(irq_clear), .count(count), .running(running),
    .expired(expired), .irq(irq)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: m_st 0=stopped, 1=counting, 2=one-shot finished.
  int m_count, m_reload, m_ps, m_st;
  bit m_exp, m_irq;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_count = 0; m_reload = 0; m_ps = 0; m_st = 0; m_exp = 0; m_irq = 0;
    end else begin
      bit ex;
      ex = 0;
      if (load) begin
        m_reload = load_value;
        m_count  = load_value;
        m_ps     = 0;
        if (stop || load_value == 0) m_st = 0;
        else m_st = (start || m_st == 1) ? 1 : 0;
      end else if (stop) begin
        if (m_st == 1) m_st = 0;
      end else if (start && m_st != 1) begin
        if (m_count == 0) m_count = m_reload;
        if (m_count != 0) begin m_st = 1; m_ps = 0; end
      end else if (m_st == 1) begin
        if (m_ps >= prescale) begin
          m_ps = 0;
          if (m_count == 1) begin
            ex = 1;
            m_count = periodic ? m_reload : 0;
            if (!periodic) m_st = 2;
          end else if (m_count > 1) begin
            m_count = m_count - 1;
          end
        end else begin
          m_ps = m_ps + 1;
        end
      end
      m_exp = ex;
      m_irq = ex || (m_irq && !irq_clear);
    end
  end

  always @(negedge clock) begin
    chk("model_count",   count,   m_count);
    chk("model_running", running, (m_st == 1));
    chk("model_expired", expired, m_exp);
    chk("model_irq",     irq,     m_irq);
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic clr();
    load = 0; start = 0; stop = 0; irq_clear = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
    $fatal(1);
  end

  initial begin
    int edges;
    bit seen;
    #2;
    chk("reset_count", count, 0);
    chk("reset_running", running, 0);
    chk("reset_irq", irq, 0);
    step(); reset_n = 1;
    step();

    // One-shot, prescale 0, load 5 then start
    load = 1; load_value = 5; step(); clr();
    chk("load5_count", count, 5);
    chk("load5_idle", running, 0);
    start = 1; step(); clr();
    chk("start_running", running, 1);
    for (int i = 4; i >= 0; i--) begin
      step();
      chk("oneshot_count", count, i);
      chk("oneshot_expired", expired, (i == 0));
    end
    chk("oneshot_irq", irq, 1);
    chk("oneshot_done", running, 0);
    step();
    chk("expired_one_cycle", expired, 0);
    irq_clear = 1; step(); clr();
    chk("irq_cleared", irq, 0);

    // Periodic, prescale 2, reload 3: expiry every 9 edges
    prescale = 2; periodic = 1;
    load = 1; load_value = 3; step(); clr();
    start = 1; step(); clr();
    for (int k = 1; k <= 36; k++) begin
      step();
      chk("periodic_expired", expired, (k % 9 == 0));
      chk("periodic_running", running, 1);
      if (k % 9 == 0) chk("periodic_reload", count, 3);
    end
    stop = 1; step(); clr();
    chk("periodic_stopped", running, 0);

    // Load 6 + Start together, stop at 3, hold, resume
    prescale = 0; periodic = 0;
    load = 1; start = 1; load_value = 6; step(); clr();
    chk("loadstart_count", count, 6);
    chk("loadstart_running", running, 1);
    step(3);
    chk("pre_stop_count", count, 3);
    stop = 1; step(); clr();
    chk("stop_hold", count, 3);
    for (int k = 0; k < 10; k++) begin
      step();
      chk("hold_count", count, 3);
      chk("hold_noexp", expired, 0);
    end
    start = 1; step(); clr();
    step(2);
    chk("resume_no_exp_yet", expired, 0);
    step();
    chk("resume_expired", expired, 1);
    chk("resume_count", count, 0);

    // Expiry coincident with IrqClear: set wins
    irq_clear = 1; step(); clr();
    load = 1; start = 1; load_value = 2; step(); clr();
    step();
    chk("pre_exp_count", count, 1);
    irq_clear = 1; step();
    chk("exp_clear_expired", expired, 1);
    chk("exp_clear_irq", irq, 1);
    step(); clr();
    chk("irq_clear_after", irq, 0);

    // Load + Stop while running
    load = 1; start = 1; load_value = 9; step(); clr();
    step(2);
    load = 1; stop = 1; load_value = 7; step(); clr();
    chk("loadstop_count", count, 7);
    chk("loadstop_idle", running, 0);
    stop = 1; start = 1; step(); clr();
    chk("stopstart_stopped", running, 0);

    // Load 0 while running
    start = 1; step(); clr();
    chk("restart_running", running, 1);
    step();
    load = 1; load_value = 0; step(); clr();
    chk("load0_count", count, 0);
    chk("load0_idle", running, 0);
    chk("load0_noexp", expired, 0);
    start = 1; step(); clr();
    chk("start_zero_ignored", running, 0);

    // Prescale lowered below PS gives a tick on the next edge
    prescale = 7;
    load = 1; start = 1; load_value = 2; step(); clr();
    step(5);
    chk("ps_wait_count", count, 2);
    prescale = 1; step();
    chk("ps_lowered_tick", count, 1);
    stop = 1; step(); clr();

    // Asynchronous reset mid-run with Count=7
    prescale = 0;
    load = 1; start = 1; load_value = 7; step(); clr();
    chk("prereset_count", count, 7);
    #2 reset_n = 0;
    #1;
    chk("async_count", count, 0);
    chk("async_running", running, 0);
    chk("async_expired", expired, 0);
    chk("async_irq", irq, 0);
    step(); reset_n = 1;
    step();

    // Full-scale load: expiry exactly 255 edges after Start
    load = 1; load_value = 8'hFF; step(); clr();
    start = 1; step(); clr();
    edges = 0; seen = 0;
    while (!seen && edges < 300) begin
      step();
      edges++;
      if (expired) seen = 1;
    end
    chk("full_scale_edges", edges, 255);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/down_timer.md
Name: down_timer

Overview:
Loadable down-counting timer with prescaler, one-shot/periodic modes, a terminal-count pulse and a sticky interrupt flag. It is the counterpart to the free-running up-counter: software loads a count, the block counts it down to zero, and then it signals expiry. It sits in the FPGA simulation peripheral set and is driven by the CPU register interface. It is used for delays and periodic ticks.

Parameters:
WIDTH, 8, bit width of count and reload registers
PS_WIDTH, 4, bit width of prescale compare value

Ports:
Clock  in  1  system clock; all logic on posedge
Reset_n  in  1  asynchronous, active-low reset
Load  in  1  1-cycle strobe; Reload<=LoadValue, Count<=LoadValue
LoadValue  in  WIDTH  value captured on Load
Start  in  1  1-cycle strobe; begin/resume counting
Stop  in  1  1-cycle strobe; pause counting, hold Count
Periodic  in  1  1=auto-reload on expiry, 0=one-shot; sampled at expiry tick
Prescale  in  PS_WIDTH  tick every Prescale+1 cycles while running; sampled live
IrqClear  in  1  clears Irq
Count  out  WIDTH  current count (registered)
Running  out  1  high in RUN state
Expired  out  1  registered 1-cycle pulse on reaching terminal count
Irq  out  1  sticky expiry flag

Behaviour:
- Reset (Reset_n=0, asynchronous, effective immediately, including mid-count): state=IDLE, Count=0, Reload=0, PS=0, Running=0, Expired=0, Irq=0.
- States:
  - IDLE: stopped.
  - RUN: counting.
  - DONE: one-shot expired, Count=0.
  - Running = (state==RUN).
- Control priority within one cycle: Load > Stop > Start.
- Load (any state):
  - Reload<=LoadValue; Count<=LoadValue; PS<=0.
  - No tick or expiry in that cycle.
  - State result: Load+Start with LoadValue!=0 -> RUN. Load+Stop -> IDLE. Load alone in RUN with LoadValue!=0 -> stays RUN. Load with LoadValue==0 -> IDLE. Load alone in DONE -> IDLE.
- Stop:
  - RUN -> IDLE; Count held; PS held.
  - Ignored in IDLE/DONE.
- Start (IDLE or DONE, without Load/Stop):
  - Count!=0 -> RUN.
  - Count==0 and Reload!=0 -> Count<=Reload, RUN.
  - Count==0 and Reload==0 -> ignored.
  - PS<=0 on entry to RUN.
  - Ignored in RUN.
- Prescaler (RUN only):
  - Each cycle: if PS>=Prescale then tick=1 and PS<=0; else PS<=PS+1.
  - Prescale lowered below PS yields a tick on the next cycle.
- Tick:
  - Count>1 -> Count<=Count-1.
  - Count==1 -> expiry.
- Expiry:
  - Expired=1 on the same edge as the Count update, for exactly one cycle.
  - Irq<=1.
  - Periodic=1: Count<=Reload, stay RUN (period = Reload*(Prescale+1) cycles).
  - Periodic=0: Count<=0, state DONE.
- Latency: with Prescale=P, the first tick occurs P+1 edges after the edge that sampled Start. Expiry occurs Reload*(P+1) edges after the Start edge.
- Irq:
  - Set on expiry; cleared by IrqClear.
  - Expiry and IrqClear in the same cycle -> Irq=1 (set wins).
- Arithmetic:
  - Count never wraps below 0.
  - LoadValue=2^WIDTH-1 is legal.
  - PS is PS_WIDTH bits and never exceeds 2^PS_WIDTH-1.
- Expired defaults to 0 in every cycle without expiry.

Test Plan:
- Reset_n=0 at arbitrary time, including mid-RUN with Count=7 -> Count=0, Running=0, Expired=0, Irq=0 immediately (before next edge).
- Prescale=0, Periodic=0, Load 5, then Start -> Count 4,3,2,1,0 on 5 consecutive edges; Expired high only after 5th edge; Irq=1; state DONE; Running=0.
- Prescale=2, Periodic=1, Load 3, Start -> Expired pulses every 9 cycles for 4 periods; Count reloads to 3 each time; Running stays 1.
- Prescale=0, Load 6, Start; Stop when Count=3 -> Count holds 3 for 10 cycles, no Expired. Start -> expiry 3 edges later.
- Simultaneous events:
  - Expiry with IrqClear -> Irq=1.
  - Load 4 + Start same cycle -> Count=4, Running=1.
  - Load+Stop in RUN -> IDLE, Count=LoadValue.
  - Stop+Start -> stopped.
- Load 0 while RUN -> Count=0, IDLE, no Expired.
- Start with Count=0, Reload=0 -> stays IDLE.
- Load 255 (WIDTH=8), Start, Prescale=0 -> expiry after exactly 255 edges.
